// File: rtl/inject_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : inject_scheduler
// Brief    : Per-destination round-robin arbiter feeding the merge/exchange
//            network through a registered per-lane word bus.
//            Optional macro INJECT_CONFLICT_CNT_EN enables the saturating
//            denied-request cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module inject_scheduler #(
    parameter  int PORT_NUB    = 16,
    parameter  int DATA_WIDTH  = 32,
    localparam int AW          = $clog2(PORT_NUB),
    localparam int WIDTH_PORT  = 1 + 2*AW + DATA_WIDTH,
    localparam int WIDTH_TOTAL = PORT_NUB*WIDTH_PORT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [PORT_NUB-1:0]            req_valid,
    input  logic [PORT_NUB*AW-1:0]         req_dest,
    input  logic [PORT_NUB*DATA_WIDTH-1:0] req_data,
    output logic [PORT_NUB-1:0]            req_ready,
    input  logic                           net_en,
    output logic [WIDTH_TOTAL-1:0]         net_out,
    output logic [15:0]                    conflict_cnt
);

    logic [AW-1:0]          r_ptr [PORT_NUB];
    logic [WIDTH_TOTAL-1:0] r_net_out;

    logic [PORT_NUB-1:0]    w_grant;
    logic [PORT_NUB-1:0]    w_dest_hit;
    logic [AW-1:0]          w_winner [PORT_NUB];
    logic [AW-1:0]          w_idx;
    logic [WIDTH_TOTAL-1:0] w_lane;

    // Each arbiter scans upward from its pointer; AW-bit addition gives the wrap.
    always_comb begin
        w_grant    = '0;
        w_dest_hit = '0;
        w_idx      = '0;
        for (int d = 0; d < PORT_NUB; d++) begin
            w_winner[d] = '0;
        end
        for (int d = 0; d < PORT_NUB; d++) begin
            for (int k = 0; k < PORT_NUB; k++) begin
                w_idx = r_ptr[d] + AW'(k);
                if (!w_dest_hit[d] && req_valid[w_idx] &&
                    (req_dest[int'(w_idx)*AW +: AW] == AW'(d))) begin
                    w_grant[w_idx] = 1'b1;
                    w_dest_hit[d]  = 1'b1;
                    w_winner[d]    = w_idx;
                end
            end
        end
    end

    assign req_ready = (rst_n && net_en) ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < PORT_NUB; d++) begin
                r_ptr[d] <= '0;
            end
        end else if (net_en) begin
            for (int d = 0; d < PORT_NUB; d++) begin
                if (w_dest_hit[d]) begin
                    r_ptr[d] <= w_winner[d] + AW'(1);
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < PORT_NUB; i++) begin : g_lane
            localparam logic [AW-1:0] c_src = AW'(i);
            assign w_lane[i*WIDTH_PORT +: WIDTH_PORT] = req_ready[i] ?
                {1'b1, req_dest[i*AW +: AW], c_src, req_data[i*DATA_WIDTH +: DATA_WIDTH]} :
                '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_net_out <= '0;
        end else begin
            r_net_out <= w_lane;
        end
    end

    assign net_out = r_net_out;

`ifdef INJECT_CONFLICT_CNT_EN
    logic [15:0] r_conflict_cnt;
    logic        w_denied;

    assign w_denied = net_en && (|(req_valid & ~w_grant));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
        end else if (w_denied && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`else
    assign conflict_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inject_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_inject_scheduler
// Brief    : Scoreboard bench for inject_scheduler (16 ports, 32-bit data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inject_scheduler;

    localparam int N  = 16;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int WP = 1 + 2*AW + DW;
    localparam int WT = N*WP;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_dest;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            net_en;
    logic [WT-1:0]   net_out;
    logic [15:0]     conflict_cnt;

    logic            v   [N];
    logic [AW-1:0]   dst [N];
    logic [DW-1:0]   dat [N];

    logic [WT-1:0]   sb [$];
    int              total = 0;
    int              bad   = 0;

    inject_scheduler #(.PORT_NUB(N), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_dest     (req_dest),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .net_en       (net_en),
        .net_out      (net_out),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] cexp(input logic [15:0] n);
`ifdef INJECT_CONFLICT_CNT_EN
        return n;
`else
        return 16'h0000;
`endif
    endfunction

    // Expected network word for a hand-chosen grant mask.
    function automatic logic [WT-1:0] lanes(input logic [N-1:0] mask);
        logic [WT-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) w[i*WP +: WP] = {1'b1, dst[i], AW'(i), dat[i]};
        end
        return w;
    endfunction

    task automatic clear();
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0; dst[i] = '0; dat[i] = '0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = v[i];
            req_dest[i*AW +: AW]   = dst[i];
            req_data[i*DW +: DW]   = dat[i];
        end
    endtask

    task automatic cyc(input logic rst, input logic en, input logic [N-1:0] exp_rdy,
                       input logic [WT-1:0] exp_net, input string nm);
        @(negedge clk);
        rst_n  = rst;
        net_en = en;
        drive();
        #1;
        total++;
        if (req_ready !== exp_rdy) begin
            bad++;
            $display("FAIL %s req_ready got=%h exp=%h", nm, req_ready, exp_rdy);
        end
        sb.push_back(exp_net);
    endtask

    task automatic chk_cnt(input logic [15:0] e, input string nm);
        total++;
        if (conflict_cnt !== e) begin
            bad++;
            $display("FAIL %s conflict_cnt got=%h exp=%h", nm, conflict_cnt, e);
        end
    endtask

    // Monitor: one registered word per cycle, compared after the edge settles.
    always @(posedge clk) begin
        #2;
        if (sb.size() > 0) begin
            logic [WT-1:0] e;
            e = sb.pop_front();
            total++;
            if (net_out !== e) begin
                bad++;
                $display("FAIL net_out got=%h exp=%h", net_out, e);
            end
        end
    end

    initial begin
        rst_n = 1'b0; net_en = 1'b0;
        req_valid = '0; req_dest = '0; req_data = '0;
        clear();

        cyc(1'b0, 1'b1, 16'h0000, '0, "reset0");
        cyc(1'b0, 1'b1, 16'h0000, '0, "reset1");
        for (int c = 0; c < 5; c++) begin
            cyc(1'b1, 1'b1, 16'h0000, '0, "idle");
            if (c == 0) chk_cnt(16'h0000, "cnt_after_reset");
        end

        // Permutation: every ingress to its own destination.
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1; dst[i] = AW'(i); dat[i] = 32'hA000 + i;
        end
        cyc(1'b1, 1'b1, 16'hFFFF, lanes(16'hFFFF), "perm");
        clear();
        cyc(1'b1, 1'b1, 16'h0000, '0, "perm_idle");
        chk_cnt(16'h0000, "cnt_perm");

        // Three ingresses fight for destination 7.
        cyc(1'b0, 1'b1, 16'h0000, '0, "reset_t3");
        v[0] = 1'b1; v[3] = 1'b1; v[15] = 1'b1;
        dst[0] = 4'd7; dst[3] = 4'd7; dst[15] = 4'd7;
        dat[0] = 32'h300; dat[3] = 32'h303; dat[15] = 32'h30F;
        cyc(1'b1, 1'b1, 16'h0001, lanes(16'h0001), "rr0");
        chk_cnt(16'h0000, "cnt_t3_start");
        cyc(1'b1, 1'b1, 16'h0008, lanes(16'h0008), "rr3");
        cyc(1'b1, 1'b1, 16'h8000, lanes(16'h8000), "rr15");
        cyc(1'b1, 1'b1, 16'h0001, lanes(16'h0001), "rr0_wrap");
        cyc(1'b1, 1'b1, 16'h0008, lanes(16'h0008), "rr3_again");
        clear();
        cyc(1'b1, 1'b1, 16'h0000, '0, "t3_idle");
        chk_cnt(cexp(16'd5), "cnt_t3");

        // Destination 2 with network stalls; pointer must survive the stall.
        v[5] = 1'b1; v[9] = 1'b1; dst[5] = 4'd2; dst[9] = 4'd2;
        dat[5] = 32'h500; dat[9] = 32'h900;
        cyc(1'b1, 1'b1, 16'h0020, lanes(16'h0020), "d2_first");
        for (int c = 0; c < 3; c++) cyc(1'b1, 1'b0, 16'h0000, '0, "d2_stall");
        chk_cnt(cexp(16'd6), "cnt_stall");
        cyc(1'b1, 1'b1, 16'h0200, lanes(16'h0200), "d2_resume9");
        cyc(1'b1, 1'b1, 16'h0020, lanes(16'h0020), "d2_then5");
        clear();
        cyc(1'b1, 1'b1, 16'h0000, '0, "t4_idle");
        chk_cnt(cexp(16'd8), "cnt_t4");

        // Reset while ingress 4 is granted.
        v[4] = 1'b1; v[6] = 1'b1; dst[4] = 4'd1; dst[6] = 4'd1;
        dat[4] = 32'h400; dat[6] = 32'h600;
        cyc(1'b1, 1'b1, 16'h0010, lanes(16'h0010), "pre_rst4");
        cyc(1'b0, 1'b1, 16'h0000, '0, "mid_rst0");
        cyc(1'b0, 1'b1, 16'h0000, '0, "mid_rst1");
        chk_cnt(16'h0000, "cnt_mid_rst");
        cyc(1'b1, 1'b1, 16'h0010, lanes(16'h0010), "post_rst4");
        cyc(1'b1, 1'b1, 16'h0040, lanes(16'h0040), "post_rst6");
        chk_cnt(cexp(16'd1), "cnt_post_rst");

        // Continuous conflict on destination 0 for saturation.
        clear();
        v[0] = 1'b1; v[1] = 1'b1; dat[0] = 32'hC0; dat[1] = 32'hC1;
        cyc(1'b1, 1'b1, 16'h0001, lanes(16'h0001), "sat_first");
`ifdef INJECT_CONFLICT_CNT_EN
        repeat (65540) @(posedge clk);
`else
        repeat (10) @(posedge clk);
`endif
        clear();
        cyc(1'b1, 1'b1, 16'h0000, '0, "sat_idle0");
        chk_cnt(cexp(16'hFFFF), "cnt_sat");
        cyc(1'b1, 1'b1, 16'h0000, '0, "sat_idle1");
        chk_cnt(cexp(16'hFFFF), "cnt_sat_hold");

        repeat (3) @(posedge clk);
        #3;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
